// File: rtl/fp_add_pkg.sv
// Purpose: shared types and constants for the FP32 adder pipeline stages.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: QNaN/exponent constants, skid state enum, op_fields_t bundle handed between stages,
//           and the effective-exponent helper (denormals behave as exponent 1).
package fp_add_pkg;

  localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_MAX       = 8'hFF;
  localparam int          SHIFT_SAT_DEF = 26;
  // Tag field is sized for the widest tag any stage may carry; narrower tags zero-extend.
  localparam int          TAG_W_MAX     = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic [30:0]          large_val;   // {exp,mant} of larger magnitude
    logic [30:0]          small_val;   // {exp,mant} of smaller magnitude
    logic                 large_sign;
    logic                 small_sign;
    logic [7:0]           large_e;
    logic [7:0]           small_e;
    logic [7:0]           shift_n;
    logic                 special;
    logic [31:0]          special_res;
    logic [TAG_W_MAX-1:0] tag;
  } op_fields_t;

  // Denormals share the scale of exponent 1, so alignment treats e==0 as 1.
  function automatic logic [7:0] eff_exp(input logic [7:0] e);
    return (e == 8'd0) ? 8'd1 : e;
  endfunction

endpackage

// File: rtl/fp_operand_classify.sv
// Purpose: orders an FP32 operand pair by magnitude, computes alignment shift, resolves specials.
// Latency: combinational.
// Backpressure: none (pure function of a/b/tag).
// Ports: a, b (raw IEEE-754 single), tag (sequence tag to attach) -> fields (op_fields_t bundle).
module fp_operand_classify
  import fp_add_pkg::*;
#(
  parameter int SHIFT_SAT = SHIFT_SAT_DEF
) (
  input  logic [31:0]          a,
  input  logic [31:0]          b,
  input  logic [TAG_W_MAX-1:0] tag,
  output op_fields_t           fields
);

  localparam logic [7:0] SAT = 8'(SHIFT_SAT);

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic a_is_large;
  logic [31:0] lg, sm;
  logic [7:0]  diff;

  assign a_nan  = (a[30:23] == EXP_MAX) && (a[22:0] != 23'd0);
  assign b_nan  = (b[30:23] == EXP_MAX) && (b[22:0] != 23'd0);
  assign a_inf  = (a[30:23] == EXP_MAX) && (a[22:0] == 23'd0);
  assign b_inf  = (b[30:23] == EXP_MAX) && (b[22:0] == 23'd0);
  assign a_zero = (a[30:0] == 31'd0);
  assign b_zero = (b[30:0] == 31'd0);

  always_comb begin
    fields     = '0;
    // Unsigned compare of {exp,mant} is a magnitude compare; ties keep a as large.
    a_is_large = (a[30:0] >= b[30:0]);
    lg         = a_is_large ? a : b;
    sm         = a_is_large ? b : a;
    // Never negative: the larger magnitude always has the larger-or-equal exponent.
    diff       = eff_exp(lg[30:23]) - eff_exp(sm[30:23]);

    fields.large_val  = lg[30:0];
    fields.small_val  = sm[30:0];
    fields.large_sign = lg[31];
    fields.small_sign = sm[31];
    fields.large_e    = lg[30:23];
    fields.small_e    = sm[30:23];
    fields.shift_n    = (diff > SAT) ? SAT : diff;
    fields.tag        = tag;

    if (a_nan || b_nan) begin
      fields.special     = 1'b1;
      fields.special_res = FP32_QNAN;
    end else if (a_inf && b_inf && (a[31] != b[31])) begin
      fields.special     = 1'b1;
      fields.special_res = FP32_QNAN;
    end else if (a_inf) begin
      // Covers like-signed Inf pairs as well: a and b are the same value then.
      fields.special     = 1'b1;
      fields.special_res = a;
    end else if (b_inf) begin
      fields.special     = 1'b1;
      fields.special_res = b;
    end else if (a_zero && b_zero) begin
      // -0 only when both zeros are negative (round-to-nearest rule).
      fields.special     = 1'b1;
      fields.special_res = {a[31] & b[31], 31'd0};
    end
  end

endmodule

// File: rtl/fp_add_operand_stage.sv
// Purpose: registered operand front end of the FP32 adder (classify + 2-entry skid + sequence tag).
// Latency: 1 cycle in->out, throughput 1 op/cycle.
// Backpressure: out_ready low parks one op in main and one in skid; in_ready drops only when both full.
// Ports: clk/rst_n; in_valid/in_ready/a/b upstream; out_valid/out_ready + ordered fields, shift_n,
//        special/special_res and out_tag downstream.
module fp_add_operand_stage
  import fp_add_pkg::*;
#(
  parameter int TAG_W     = 4,
  parameter int SHIFT_SAT = SHIFT_SAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [30:0]      large_val,
  output logic [30:0]      small_val,
  output logic             large_sign,
  output logic             small_sign,
  output logic [7:0]       large_e,
  output logic [7:0]       small_e,
  output logic [7:0]       shift_n,
  output logic             special,
  output logic [31:0]      special_res,
  output logic [TAG_W-1:0] out_tag
);

  skid_state_t     state_q, state_d;
  op_fields_t      main_q, main_d;
  op_fields_t      skid_q, skid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  op_fields_t      in_fields;
  logic            accept;
  logic            tag_unused;

  fp_operand_classify #(
    .SHIFT_SAT (SHIFT_SAT)
  ) u_classify (
    .a      (a),
    .b      (b),
    .tag    (TAG_W_MAX'(tag_q)),
    .fields (in_fields)
  );

  // Both handshake flags come straight from the state register.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    tag_d   = tag_q + TAG_W'(accept);
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = in_fields;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && out_ready) begin
          main_d = in_fields;       // main drains and reloads in the same cycle
        end else if (accept) begin
          skid_d  = in_fields;      // main is held, park the newcomer
          state_d = ST_TWO;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_ready) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      tag_q   <= tag_d;
    end
  end

  assign large_val   = main_q.large_val;
  assign small_val   = main_q.small_val;
  assign large_sign  = main_q.large_sign;
  assign small_sign  = main_q.small_sign;
  assign large_e     = main_q.large_e;
  assign small_e     = main_q.small_e;
  assign shift_n     = main_q.shift_n;
  assign special     = main_q.special;
  assign special_res = main_q.special_res;
  assign out_tag     = main_q.tag[TAG_W-1:0];
  // Upper tag bits are zero-extension only.
  assign tag_unused  = ^main_q.tag;

endmodule

// File: tb/tb_fp_add_operand_stage.sv
// Purpose: self-checking bench for fp_add_operand_stage (directed cases, stall stream, reset, tag wrap).
// Latency: expects each accepted op to appear one cycle later in order.
// Backpressure: drives out_ready patterns and honours in_ready.
module tb_fp_add_operand_stage;
  import fp_add_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [30:0] large_val, small_val;
  logic        large_sign, small_sign;
  logic [7:0]  large_e, small_e, shift_n;
  logic        special;
  logic [31:0] special_res;
  logic [3:0]  out_tag;

  fp_add_operand_stage #(.TAG_W(4), .SHIFT_SAT(26)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .large_val(large_val), .small_val(small_val),
    .large_sign(large_sign), .small_sign(small_sign), .large_e(large_e), .small_e(small_e),
    .shift_n(shift_n), .special(special), .special_res(special_res), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    op_fields_t  f;
    bit          dir;
    logic [30:0] d_large;
    logic [7:0]  d_sh;
    logic        d_sp;
    logic [31:0] d_res;
  } sb_t;

  sb_t         sb_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_out = 0;
  logic [3:0]  tb_tag = '0;
  bit          dir_en = 1'b0;
  logic [30:0] dir_large = '0;
  logic [7:0]  dir_sh = '0;
  logic        dir_sp = 1'b0;
  logic [31:0] dir_res = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction
  function automatic bit is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 0);
  endfunction

  // Reference model of one operation.
  function automatic op_fields_t model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] t);
    op_fields_t  m;
    logic [31:0] lo, hi;
    int          el, es, d;
    m = '0;
    if ((x & 32'h7FFF_FFFF) >= (y & 32'h7FFF_FFFF)) begin hi = x; lo = y; end
    else begin hi = y; lo = x; end
    m.large_val  = hi[30:0];
    m.small_val  = lo[30:0];
    m.large_sign = hi[31];
    m.small_sign = lo[31];
    m.large_e    = hi[30:23];
    m.small_e    = lo[30:23];
    el = int'(hi[30:23]); if (el == 0) el = 1;
    es = int'(lo[30:23]); if (es == 0) es = 1;
    d = el - es;
    if (d > 26) d = 26;
    m.shift_n = 8'(d);
    if (is_nan(x) || is_nan(y)) begin m.special = 1; m.special_res = 32'h7FC0_0000; end
    else if (is_inf(x) && is_inf(y) && x[31] != y[31]) begin m.special = 1; m.special_res = 32'h7FC0_0000; end
    else if (is_inf(x)) begin m.special = 1; m.special_res = x; end
    else if (is_inf(y)) begin m.special = 1; m.special_res = y; end
    else if (x[30:0] == 0 && y[30:0] == 0) begin m.special = 1; m.special_res = {x[31] & y[31], 31'd0}; end
    m.tag = TAG_W_MAX'(t);
    return m;
  endfunction

  // Monitor: compare on output handshake, then record accepted inputs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_out++;
        n_chk++;
        assert (sb_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_output observed tag=%h expected no output", out_tag);
        end
        if (sb_q.size() != 0) begin
          sb_t e;
          e = sb_q.pop_front();
          chk("large_val", {1'b0, large_val}, {1'b0, e.f.large_val});
          chk("small_val", {1'b0, small_val}, {1'b0, e.f.small_val});
          chk("signs", {30'd0, large_sign, small_sign}, {30'd0, e.f.large_sign, e.f.small_sign});
          chk("exps", {16'd0, large_e, small_e}, {16'd0, e.f.large_e, e.f.small_e});
          chk("shift_n", {24'd0, shift_n}, {24'd0, e.f.shift_n});
          chk("special", {31'd0, special}, {31'd0, e.f.special});
          chk("special_res", special_res, e.f.special_res);
          chk("out_tag", {28'd0, out_tag}, {28'd0, e.f.tag[3:0]});
          if (e.dir) begin
            chk("dir_large", {1'b0, large_val}, {1'b0, e.d_large});
            chk("dir_shift", {24'd0, shift_n}, {24'd0, e.d_sh});
            chk("dir_special", {31'd0, special}, {31'd0, e.d_sp});
            chk("dir_res", special_res, e.d_res);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb_t n;
        n.f = model(a, b, tb_tag);
        n.dir = dir_en; n.d_large = dir_large; n.d_sh = dir_sh; n.d_sp = dir_sp; n.d_res = dir_res;
        sb_q.push_back(n);
        tb_tag = tb_tag + 4'd1;
      end
    end
  end

  task automatic send(input logic [31:0] xa, input logic [31:0] xb);
    bit ok;
    ok = 0;
    a = xa; b = xb; in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    n_chk++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL send_timeout observed in_ready=%b expected 1 within 30 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic dsend(input logic [31:0] xa, input logic [31:0] xb, input logic [30:0] lg,
                       input logic [7:0] sh, input logic sp, input logic [31:0] res);
    dir_en = 1; dir_large = lg; dir_sh = sh; dir_sp = sp; dir_res = res;
    send(xa, xb);
    dir_en = 0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_empty", sb_q.size(), 0);
  endtask

  logic [31:0] ops_a[5];
  logic [31:0] ops_b[5];
  logic [30:0] held_large;

  initial begin
    int idx, stall_cnt, out0;
    bit acc;

    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_large", {1'b0, large_val}, 0);
    chk("rst_special_res", special_res, 0);
    chk("rst_tag", {28'd0, out_tag}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Directed cases
    dsend(32'h3F80_0000, 32'h4000_0000, 31'h4000_0000, 8'd1,  1'b0, 32'h0);
    dsend(32'h4B80_0000, 32'h3F80_0000, 31'h4B80_0000, 8'd24, 1'b0, 32'h0);
    dsend(32'h7F00_0000, 32'h3F80_0000, 31'h7F00_0000, 8'd26, 1'b0, 32'h0);
    dsend(32'h7F80_0000, 32'hFF80_0000, 31'h7F80_0000, 8'd0,  1'b1, 32'h7FC0_0000);
    dsend(32'h8000_0000, 32'h8000_0000, 31'h0,         8'd0,  1'b1, 32'h8000_0000);
    dsend(32'h0000_0001, 32'h0080_0000, 31'h0080_0000, 8'd0,  1'b0, 32'h0);
    dsend(32'h7FC0_0001, 32'h3F80_0000, 31'h7FC0_0001, 8'd26, 1'b1, 32'h7FC0_0000);
    dsend(32'hFF80_0000, 32'h3F80_0000, 31'h7F80_0000, 8'd26, 1'b1, 32'hFF80_0000);
    dsend(32'h0000_0000, 32'h8000_0000, 31'h0,         8'd0,  1'b1, 32'h0000_0000);
    dsend(32'h3F80_0000, 32'hBF80_0000, 31'h3F80_0000, 8'd0,  1'b0, 32'h0);
    dsend(32'hFF80_0000, 32'hFF80_0000, 31'h7F80_0000, 8'd0,  1'b1, 32'hFF80_0000);
    drain();

    // Stream of 5 with out_ready low for 3 cycles while the first op is held
    for (int i = 0; i < 5; i++) begin
      ops_a[i] = {1'b0, 8'(100 + $urandom_range(0, 40)), 23'($urandom)};
      ops_b[i] = {1'($urandom), 8'(100 + $urandom_range(0, 40)), 23'($urandom)};
    end
    held_large = model(ops_a[0], ops_b[0], 4'd0).large_val;
    idx = 0; stall_cnt = 0; out0 = n_out;
    for (int cyc = 0; cyc < 40 && (idx < 5 || sb_q.size() != 0); cyc++) begin
      out_ready = !(cyc >= 1 && cyc <= 3);
      in_valid  = (idx < 5);
      if (idx < 5) begin a = ops_a[idx]; b = ops_b[idx]; end
      @(negedge clk);
      if (!in_ready) stall_cnt++;
      if (cyc == 2 || cyc == 3) chk("stall_hold_large", {1'b0, large_val}, {1'b0, held_large});
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("stall_in_ready_low_cycles", stall_cnt, 3);
    chk("stall_all_accepted", idx, 5);
    chk("stall_output_count", n_out - out0, 5);
    drain();

    // Reset with both entries occupied
    out_ready = 1'b0;
    send(32'h4040_0000, 32'h3F80_0000);
    send(32'h4080_0000, 32'h3F80_0000);
    chk("two_in_ready", {31'd0, in_ready}, 0);
    chk("two_out_valid", {31'd0, out_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_in_ready", {31'd0, in_ready}, 1);
    chk("midrst_large", {1'b0, large_val}, 0);
    sb_q.delete();
    tb_tag = 4'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_out_valid", {31'd0, out_valid}, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h3F80_0000, 32'h4000_0000);
    #1;
    chk("postrst_tag", {28'd0, out_tag}, 0);
    drain();

    // Back-to-back stream long enough to wrap the tag
    for (int i = 0; i < 20; i++)
      send({1'($urandom), 8'($urandom_range(0, 254)), 23'($urandom)},
           {1'($urandom), 8'($urandom_range(0, 254)), 23'($urandom)});
    drain();
    chk("end_sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
